// File: rtl/cmu_fpu_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cmu_fpu_arbiter: round-robin arbiter sharing one FP unit among N_REQ;   |
// | CMU_ARB_TIMEOUT_EN adds a watchdog abort.            Revision: 1.0      |
// +-------------------------------------------------------------------------+
module cmu_fpu_arbiter #(
  parameter int DBL_WIDTH   = 64,
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DBL_WIDTH-1:0] req_a,
  input  logic [N_REQ*DBL_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]           req_ack,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [DBL_WIDTH-1:0]       rsp_data,
  output logic                       rsp_err,
  output logic                       fpu_valid,
  input  logic                       fpu_ready,
  input  logic                       fpu_finish,
  output logic [DBL_WIDTH-1:0]       fpu_a,
  output logic [DBL_WIDTH-1:0]       fpu_b,
  input  logic [DBL_WIDTH-1:0]       fpu_result,
  output logic                       busy,
  output logic [2:0]                 owner
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [2:0]           rr_ptr;
  logic [2:0]           nxt_ptr;
  logic [2:0]           win;
  logic                 win_found;
  logic [3:0]           k;
  logic [7:0]           req8;
  logic [N_REQ-1:0]     win_oh;
  logic [N_REQ-1:0]     own_oh;
  logic [DBL_WIDTH-1:0] win_a;
  logic [DBL_WIDTH-1:0] win_b;
  logic                 grant;
  logic                 done;

  generate
    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("cmu_fpu_arbiter: parameter out of range");
    end
  endgenerate

  assign req8    = 8'(req);
  assign busy    = (state == S_WAIT);
  assign nxt_ptr = (owner == 3'(N_REQ - 1)) ? 3'd0 : owner + 3'd1;

  // Rotating priority search: first set bit at or after rr_ptr, wrapping.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    k         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = {1'b0, rr_ptr} + 4'(i);
      if (k >= 4'(N_REQ)) k = k - 4'(N_REQ);
      if (!win_found && req8[k[2:0]]) begin
        win_found = 1'b1;
        win       = k[2:0];
      end
    end
  end

  always_comb begin
    win_oh = '0;
    own_oh = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_oh[i] = (win == 3'(i));
      own_oh[i] = (owner == 3'(i));
      if (win == 3'(i)) begin
        win_a = req_a[i*DBL_WIDTH +: DBL_WIDTH];
        win_b = req_b[i*DBL_WIDTH +: DBL_WIDTH];
      end
    end
  end

`ifdef CMU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             abort;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
`ifdef CMU_ARB_TIMEOUT_EN
    abort     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (win_found && fpu_ready) begin
          grant     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A finish arriving on the watchdog's last cycle still counts as success.
        if (fpu_finish) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
`ifdef CMU_ARB_TIMEOUT_EN
        else if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      owner     <= '0;
      req_ack   <= '0;
      rsp_valid <= '0;
      fpu_valid <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      rsp_data  <= '0;
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      fpu_valid <= 1'b0;
      if (grant) begin
        fpu_a     <= win_a;
        fpu_b     <= win_b;
        fpu_valid <= 1'b1;
        req_ack   <= win_oh;
        owner     <= win;
      end
      if (done) begin
        rsp_data  <= fpu_result;
        rsp_valid <= own_oh;
        rr_ptr    <= nxt_ptr;
      end
`ifdef CMU_ARB_TIMEOUT_EN
      if (abort) begin
        rsp_data  <= '0;
        rsp_valid <= own_oh;
        rr_ptr    <= nxt_ptr;
      end
`endif
    end
  end

`ifdef CMU_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= abort;
      if (grant)                 wd_cnt <= '0;
      else if (state == S_WAIT)  wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmu_fpu_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_cmu_fpu_arbiter: directed bench with response scoreboard.            |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_cmu_fpu_arbiter;
  localparam int DW = 64;
  localparam int NR = 4;
`ifdef CMU_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_a, req_b;
  logic [NR-1:0]    req_ack, rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;
  logic             fpu_valid, fpu_ready, fpu_finish;
  logic [DW-1:0]    fpu_a, fpu_b, fpu_result;
  logic             busy;
  logic [2:0]       owner;

  typedef struct packed {
    logic [NR-1:0] vld;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] A[NR];
  logic [63:0] B[NR];

  cmu_fpu_arbiter #(.DBL_WIDTH(DW), .N_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .fpu_valid(fpu_valid), .fpu_ready(fpu_ready),
    .fpu_finish(fpu_finish), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_result(fpu_result), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_issue(input string tag, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!fpu_valid && lat < 40);
    check({tag, "_issue"}, 64'(fpu_valid), 64'd1);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_valid"}, 64'(rsp_valid), 64'(e.vld));
    check({tag, "_data"},  rsp_data,       e.data);
    check({tag, "_err"},   64'(rsp_err),   64'(e.err));
  endtask

  task automatic finish_op(input string tag, input logic [63:0] res);
    fpu_finish = 1'b1;
    fpu_result = res;
    tick();
    fpu_finish = 1'b0;
    check_rsp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int nv;
    rst = 1'b1; req = '0; req_a = '0; req_b = '0;
    fpu_ready = 1'b1; fpu_finish = 1'b0; fpu_result = '0;
    for (int i = 0; i < NR; i++) begin
      A[i] = 64'h1111_0000_0000_0000 + 64'(i) * 64'h0101;
      B[i] = 64'h0000_2222_0000_0000 + 64'(i) * 64'h0010_0000;
    end

    // reset state
    tick(); tick();
    check("rst_busy",   64'(busy),  64'd0);
    check("rst_owner",  64'(owner), 64'd0);
    check("rst_pulses", 64'({req_ack, rsp_valid, fpu_valid, rsp_err}), 64'd0);
    check("rst_data",   fpu_a | fpu_b | rsp_data, 64'd0);

    // single request
    rst = 1'b0; tick();
    req_a[63:0] = 64'h3FF0_0000_0000_0000;
    req_b[63:0] = 64'h3FF0_0000_0000_0000;
    req = 4'b0001;
    sb.push_back({4'b0001, 64'h4000_0000_0000_0000, 1'b0});
    wait_issue("t1", lat);
    check("t1_lat",   64'(lat),     64'd1);
    check("t1_ack",   64'(req_ack), 64'b0001);
    check("t1_fpu_a", fpu_a,        64'h3FF0_0000_0000_0000);
    check("t1_busy",  64'(busy),    64'd1);
    req = '0;
    tick();
    check("t1_pulse", 64'({req_ack, fpu_valid}), 64'd0);
    repeat (3) tick();
    finish_op("t1_rsp", 64'h4000_0000_0000_0000);
    check("t1_busy_end", 64'(busy), 64'd0);
    tick();
    check("t1_rsp_pulse", 64'(rsp_valid), 64'd0);
    check("t1_hold",      rsp_data,       64'h4000_0000_0000_0000);

    // all requesting: order 0,1,2,3,0 from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = A[i];
      req_b[i*DW +: DW] = B[i];
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int w;
      w = n % NR;
      sb.push_back({4'(1 << w), A[w] + B[w], 1'b0});
      wait_issue("t2", lat);
      check("t2_lat",   64'(lat),     64'd1);
      check("t2_ack",   64'(req_ack), 64'(1 << w));
      check("t2_owner", 64'(owner),   64'(w));
      tick();
      check("t2_inflight", 64'({fpu_valid, busy}), 64'b01);
      if (n == 4) req = '0;
      finish_op("t2_rsp", fpu_a + fpu_b);
    end
    req = '0;

    // stalled unit, withdrawn request, then grant once ready
    fpu_ready = 1'b0;
    req = 4'b0010; tick(); tick();
    req = 4'b0100;
    nv = 0;
    repeat (10) begin
      tick();
      if (fpu_valid || (req_ack != '0)) nv++;
    end
    check("t3_no_issue", 64'(nv),   64'd0);
    check("t3_idle",     64'(busy), 64'd0);
    fpu_ready = 1'b1;
    sb.push_back({4'b0100, A[2] + B[2], 1'b0});
    wait_issue("t3", lat);
    check("t3_lat", 64'(lat),     64'd1);
    check("t3_ack", 64'(req_ack), 64'b0100);
    req = '0;
    tick(); tick();
    finish_op("t3_rsp", fpu_a + fpu_b);

    // reset while waiting abandons the operation
    req = 4'b1000;
    wait_issue("t4", lat);
    check("t4_owner", 64'(owner), 64'd3);
    req = '0;
    tick();
    rst = 1'b1;
    #1;
    check("t4_async", 64'({busy, owner}), 64'd0);
    tick();
    rst = 1'b0;
    fpu_finish = 1'b1; fpu_result = 64'hDEAD_BEEF_0000_0001;
    tick();
    fpu_finish = 1'b0;
    check("t4_no_rsp", 64'({rsp_valid, busy}), 64'd0);
    check("t4_data",   rsp_data, 64'd0);
    req = 4'b1111;
    sb.push_back({4'b0001, A[0] + B[0], 1'b0});
    wait_issue("t4b", lat);
    check("t4_restart", 64'(req_ack), 64'b0001);
    req = '0;
    tick();
    finish_op("t4_rsp", fpu_a + fpu_b);

    // stray finish while idle
    tick();
    fpu_finish = 1'b1; fpu_result = {$urandom, $urandom};
    tick();
    fpu_finish = 1'b0;
    check("t5_quiet", 64'({rsp_valid, req_ack, fpu_valid, busy}), 64'd0);
    check("t5_hold",  rsp_data, A[0] + B[0]);

`ifdef CMU_ARB_TIMEOUT_EN
    // watchdog abort, late finish ignored
    req = 4'b0010;
    sb.push_back({4'b0010, 64'd0, 1'b1});
    wait_issue("t6", lat);
    req = '0;
    nv = 0;
    do begin
      tick();
      nv++;
    end while (rsp_valid == '0 && nv < 30);
    check("t6_abort_lat", 64'(nv), 64'(TO));
    check_rsp("t6_rsp");
    fpu_finish = 1'b1; fpu_result = 64'h5555;
    tick();
    fpu_finish = 1'b0;
    check("t6_late", 64'({rsp_valid, busy}), 64'd0);

    // finish on the final watchdog cycle wins
    req = 4'b0100;
    sb.push_back({4'b0100, 64'h1234_5678, 1'b0});
    wait_issue("t7", lat);
    req = '0;
    repeat (TO - 1) tick();
    finish_op("t7_rsp", 64'h1234_5678);
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
